// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue
//   Decoupling FIFO between the IFU fetch buffer and decode. Each accepted
//   word is classified as compressed (16-bit) or full (32-bit) and normalised.
//   The normalised word is stored with its PC in a small circular buffer. The
//   oldest entry is presented to decode. A pipeline redirect (Flush) discards
//   the whole queue.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous, active-low reset
//   InValid/InReady/InWord/InPC          fetch-side push handshake
//   Flush          redirect: empty the queue at the next edge
//   OutValid/OutReady                    decode-side pop handshake
//   OutInstr/OutPC/OutCompressed/OutIllegal   head entry fields
//   Count          number of occupied entries
//
// Handshake: a transfer completes on a rising edge where valid and ready are
// both high. InReady depends only on Count and Flush, never on OutReady.
// OutValid depends only on Count. Neither side completes a transfer in a
// Flush cycle.

module fetch_instr_queue #(
  parameter int          XLEN  = 64,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [31:0]                InWord,
  input  logic [XLEN-1:0]            InPC,
  input  logic                       Flush,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [31:0]                OutInstr,
  output logic [XLEN-1:0]            OutPC,
  output logic                       OutCompressed,
  output logic                       OutIllegal,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [DEPTH-1:0] vld_q, comp_q, ill_q;
  // PC shown while the queue is empty: the last PC that was at the head.
  logic [XLEN-1:0] last_pc_q;

  logic        push, pop;
  logic        in_comp, in_ill;
  logic [31:0] in_instr;

  // Classification of the incoming word.
  assign in_comp  = (InWord[1:0] != 2'b11);
  assign in_instr = in_comp ? {16'h0000, InWord[15:0]} : InWord;
  assign in_ill   = in_comp & (InWord[15:0] == 16'h0000);

  assign InReady  = (count_q < FULL_CNT) & ~Flush;
  assign OutValid = (count_q != '0);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady & ~Flush;

  // Head outputs come only from stored state; no path from In* to Out*.
  assign OutInstr      = OutValid ? instr_q[head_q] : NOP;
  assign OutPC         = OutValid ? pc_q[head_q] : last_pc_q;
  assign OutCompressed = OutValid & comp_q[head_q];
  assign OutIllegal    = OutValid & ill_q[head_q];
  assign Count         = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      comp_q    <= '0;
      ill_q     <= '0;
      last_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      if (OutValid) begin
        last_pc_q <= pc_q[head_q];
      end
      if (Flush) begin
        // Flush overrides any push or pop offered in the same cycle.
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        vld_q   <= '0;
      end else begin
        // When both happen, head != tail because the queue is neither empty
        // (pop needs an entry) nor full (push needs space).
        if (pop) begin
          vld_q[head_q] <= 1'b0;
          head_q        <= head_q + PW'(1);
        end
        if (push) begin
          instr_q[tail_q] <= in_instr;
          pc_q[tail_q]    <= InPC;
          comp_q[tail_q]  <= in_comp;
          ill_q[tail_q]   <= in_ill;
          vld_q[tail_q]   <= 1'b1;
          tail_q          <= tail_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
module tb_fetch_instr_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            reset;
  logic            InValid;
  logic            InReady;
  logic [31:0]     InWord;
  logic [XLEN-1:0] InPC;
  logic            Flush;
  logic            OutValid;
  logic            OutReady;
  logic [31:0]     OutInstr;
  logic [XLEN-1:0] OutPC;
  logic            OutCompressed;
  logic            OutIllegal;
  logic [2:0]      Count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]     exp_q[$];
  logic [XLEN-1:0] exp_pc_q[$];

  fetch_instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .InValid(InValid), .InReady(InReady), .InWord(InWord), .InPC(InPC),
    .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr),
    .OutPC(OutPC), .OutCompressed(OutCompressed), .OutIllegal(OutIllegal),
    .Count(Count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [XLEN-1:0] pc);
    InValid = 1'b1;
    InWord  = w;
    InPC    = pc;
    tick();
    InValid = 1'b0;
  endtask

  task automatic pop_one();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  initial begin
    reset = 1'b0; InValid = 1'b0; InWord = '0; InPC = '0;
    Flush = 1'b0; OutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outvalid", OutValid, 0);
    check("rst_outinstr", OutInstr, 32'h0000_0013);
    check("rst_outpc", OutPC, 0);
    check("rst_inready", InReady, 1);
    check("rst_count", Count, 0);
    reset = 1'b1;
    tick();
    check("idle_outvalid", OutValid, 0);
    check("idle_outinstr", OutInstr, 32'h0000_0013);
    check("idle_comp", OutCompressed, 0);
    check("idle_ill", OutIllegal, 0);

    // first push: no same-cycle visibility, valid one cycle later
    InValid = 1'b1; InWord = 32'h00A0_0093; InPC = 64'h8000_0000;
    #1;
    check("no_comb_path", OutValid, 0);
    tick();
    InValid = 1'b0;
    check("p1_valid", OutValid, 1);
    check("p1_instr", OutInstr, 32'h00A0_0093);
    check("p1_comp", OutCompressed, 0);
    check("p1_pc", OutPC, 64'h8000_0000);
    check("p1_count", Count, 1);

    // compressed and illegal compressed words
    push_word(32'hFFFF_4501, 64'h8000_0004);
    push_word(32'h0000_0000, 64'h8000_0008);
    check("p3_count", Count, 3);
    check("p3_head_unchanged", OutInstr, 32'h00A0_0093);
    pop_one();
    check("cli_instr", OutInstr, 32'h0000_4501);
    check("cli_comp", OutCompressed, 1);
    check("cli_ill", OutIllegal, 0);
    check("cli_pc", OutPC, 64'h8000_0004);
    pop_one();
    check("zero_instr", OutInstr, 32'h0000_0000);
    check("zero_comp", OutCompressed, 1);
    check("zero_ill", OutIllegal, 1);
    check("zero_pc", OutPC, 64'h8000_0008);
    pop_one();
    check("empty_valid", OutValid, 0);
    check("empty_instr", OutInstr, 32'h0000_0013);
    check("empty_ill", OutIllegal, 0);
    check("empty_pc_hold", OutPC, 64'h8000_0008);
    check("empty_count", Count, 0);

    // fill to DEPTH (pointers start at 3, so this wraps)
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'h0010_0093 + (i << 20));
      exp_pc_q.push_back(64'h8000_0010 + 4 * i);
      push_word(exp_q[$], exp_pc_q[$]);
    end
    check("full_count", Count, 4);
    check("full_inready", InReady, 0);
    check("full_head", OutInstr, exp_q[0]);
    // fifth word offered while full must be ignored
    InValid = 1'b1; InWord = 32'hDEAD_BEEF; InPC = 64'h1;
    tick();
    InValid = 1'b0;
    check("full_reject_count", Count, 4);
    check("full_reject_head", OutInstr, exp_q[0]);

    // steady state: one push and one pop per cycle for 8 cycles
    for (int i = 0; i < 8; i++) begin
      logic [31:0]     w;
      logic [XLEN-1:0] pc;
      w  = 32'h0200_0113 + (i << 20);
      pc = 64'h8000_0040 + 4 * i;
      // pop happens first this cycle (full), push the following cycle
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_pc_q.pop_front());
      check("ss_after_pop_count", Count, 3);
      InValid = 1'b1; InWord = w; InPC = pc; OutReady = 1'b1;
      tick();
      InValid = 1'b0; OutReady = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_pc_q.pop_front());
      exp_q.push_back(w);
      exp_pc_q.push_back(pc);
      check("ss_count", Count, 3);
      check("ss_head_instr", OutInstr, exp_q[0]);
      check("ss_head_pc", OutPC, exp_pc_q[0]);
      // refill so the next iteration starts full again
      w  = 32'h0300_0193 + (i << 20);
      pc = 64'h8000_0080 + 4 * i;
      exp_q.push_back(w);
      exp_pc_q.push_back(pc);
      push_word(w, pc);
      check("ss_refill_count", Count, 4);
    end

    // drain in order
    while (exp_q.size() != 0) begin
      check("drain_instr", OutInstr, exp_q.pop_front());
      check("drain_pc", OutPC, exp_pc_q.pop_front());
      pop_one();
    end
    check("drain_count", Count, 0);

    // flush with Count=3 and a push+pop offered in the same cycle
    push_word(32'h0040_0093, 64'h8000_0200);
    push_word(32'h0050_0093, 64'h8000_0204);
    push_word(32'h0060_0093, 64'h8000_0208);
    check("pre_flush_count", Count, 3);
    Flush = 1'b1; InValid = 1'b1; InWord = 32'h0070_0093; InPC = 64'h8000_020C;
    OutReady = 1'b1;
    #1;
    check("flush_inready", InReady, 0);
    check("flush_outvalid", OutValid, 1);
    tick();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    check("post_flush_count", Count, 0);
    check("post_flush_valid", OutValid, 0);
    check("post_flush_instr", OutInstr, NOP);
    push_word(32'h00B0_0113, 64'h8000_0100);
    check("after_flush_valid", OutValid, 1);
    check("after_flush_instr", OutInstr, 32'h00B0_0113);
    check("after_flush_pc", OutPC, 64'h8000_0100);
    check("after_flush_count", Count, 1);

    // asynchronous reset in the middle of a cycle with Count=2
    push_word(32'h00C0_0193, 64'h8000_0104);
    check("pre_rst_count", Count, 2);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_valid", OutValid, 0);
    check("async_rst_count", Count, 0);
    check("async_rst_inready", InReady, 1);
    check("async_rst_pc", OutPC, 0);
    #1;
    reset = 1'b1;
    tick();
    push_word(32'hFFFF_4085, 64'h8000_0300);
    check("resume_count", Count, 1);
    check("resume_instr", OutInstr, 32'h0000_4085);
    check("resume_comp", OutCompressed, 1);
    check("resume_pc", OutPC, 64'h8000_0300);
    pop_one();
    check("resume_empty", OutValid, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
